reset_sequencer: RTL

Staged reset release block that sits directly downstream of the power-up timer. It takes the timer's active-high system reset and a PLL lock indication, then deasserts a set of per-domain resets one at a time, spaced by a fixed cycle delay. It asserts `Ready` once every stage is out of reset. A one-cycle soft request restarts the whole sequence.

---
 rtl/reset_sequencer.sv | 106 ++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Staged reset release: after PLL lock, per-domain resets drop one at a time, DELAY cycles apart.
// Optional RESET_SEQ_LOCK_MONITOR_EN: losing lock in COUNT/RUN restarts the sequence.
module reset_sequencer #(
   parameter int STAGES = 4,
   parameter int DELAY  = 1000
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Locked,
   input  logic              Request,
   output logic [STAGES-1:0] Stage_Reset,
   output logic              Ready
);

   localparam int CW = $clog2(DELAY + 1);
   localparam int IW = (STAGES > 1) ? $clog2(STAGES) : 1;

   typedef enum logic [1:0] {WAIT_LOCK, COUNT, RUN} state_t;

   state_t            state, state_d;
   logic              lock_meta, lock_s;
   logic [CW-1:0]     cnt, cnt_d;
   logic [IW-1:0]     idx, idx_d;
   logic [STAGES-1:0] sr_d;
   logic              rdy_d;
   logic              restart, release_now, last;

   // Locked is asynchronous to Clk
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         lock_meta <= 1'b0;
         lock_s    <= 1'b0;
      end else begin
         lock_meta <= Locked;
         lock_s    <= lock_meta;
      end
   end

`ifdef RESET_SEQ_LOCK_MONITOR_EN
   assign restart = Request | (((state == COUNT) | (state == RUN)) & ~lock_s);
`else
   assign restart = Request;
`endif

   assign release_now = (state == COUNT) && (cnt == CW'(DELAY - 1));
   assign last        = (idx == IW'(STAGES - 1));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         state       <= WAIT_LOCK;
         cnt         <= '0;
         idx         <= '0;
         Stage_Reset <= '1;
         Ready       <= 1'b0;
      end else begin
         state       <= state_d;
         cnt         <= cnt_d;
         idx         <= idx_d;
         Stage_Reset <= sr_d;
         Ready       <= rdy_d;
      end
   end

   always_comb begin
      state_d = state;
      if (restart) begin
         state_d = WAIT_LOCK;
      end else begin
         case (state)
            WAIT_LOCK: if (lock_s) state_d = COUNT;
            COUNT:     if (release_now && last) state_d = RUN;
            default:   state_d = state;
         endcase
      end
   end

   // Next values of the registered outputs and datapath; restart beats any release
   always_comb begin
      sr_d  = Stage_Reset;
      rdy_d = Ready;
      cnt_d = cnt;
      idx_d = idx;
      if (restart) begin
         sr_d  = '1;
         rdy_d = 1'b0;
         cnt_d = '0;
         idx_d = '0;
      end else begin
         case (state)
            WAIT_LOCK: cnt_d = '0;
            COUNT: begin
               if (release_now) begin
                  sr_d[idx] = 1'b0;
                  cnt_d     = '0;
                  if (last) rdy_d = 1'b1;
                  else      idx_d = idx + IW'(1);
               end else begin
                  cnt_d = cnt + CW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
